// File: rtl/ram_responder_pkg.sv
// Shared memory defines for the RAM responder: FSM encoding, default geometry,
// and the request/response records passed between the FSM and the storage.
package ram_responder_pkg;

  localparam int DEF_DEPTH   = 1024;
  localparam int DEF_LATENCY = 2;
  localparam int NUM_LANES   = 4;
  localparam int VEC_W       = 8;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_e;

  typedef logic [NUM_LANES-1:0][VEC_W-1:0] lane_vec_t;

  typedef struct packed {
    logic                 we;
    logic [29:0]          idx;
    logic [NUM_LANES-1:0] be;
    lane_vec_t            wd;
  } ram_req_t;

  typedef struct packed {
    logic      ready;
    logic      error;
    lane_vec_t data;
  } ram_rsp_t;

endpackage

// File: rtl/ram_responder_if.sv
// Initiator-to-responder memory bus: request fields one way, completion the other.
interface ram_responder_if;
  logic        request;
  logic        write_enable;
  logic [31:0] address;
  logic [3:0]  byte_select;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        error;

  modport master (
    output request, write_enable, address, byte_select, write_data,
    input  read_data, ready, error
  );

  modport slave (
    input  request, write_enable, address, byte_select, write_data,
    output read_data, ready, error
  );
endinterface

// File: rtl/ram_bank.sv
// Word storage split into independent byte lanes; write on the clock edge,
// read combinationally at the same index.
module ram_bank
  import ram_responder_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clock,
  input  logic [AW-1:0]        index,
  input  logic [NUM_LANES-1:0] strobe,
  input  lane_vec_t            wdata,
  output lane_vec_t            rdata
);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [VEC_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
      if (strobe[g]) mem[index] <= wdata[g];
    end

    assign rdata[g] = mem[index];
  end

endmodule

// File: rtl/ram_responder.sv
// Fixed-latency memory responder: accepts one request, counts down, then pulses
// ready for one cycle with load data or an out-of-range error.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic            clock,
  input  logic            reset,
  ram_responder_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  ram_req_t             req_q, req_d;
  ram_rsp_t             rsp;
  logic                 in_respond, oor;
  logic [NUM_LANES-1:0] strobe;
  lane_vec_t            rdata;

  // Byte offset within a word has no meaning for word-granular storage.
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^bus.address[1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    unique case (state_q)
      IDLE: begin
        if (bus.request) begin
          req_d.we  = bus.write_enable;
          req_d.idx = bus.address[31:2];
          req_d.be  = bus.byte_select;
          req_d.wd  = bus.write_data;
          cnt_d     = CNT_W'(LATENCY - 1);
          state_d   = (LATENCY == 1) ? RESPOND : WAIT;
        end
      end
      WAIT: begin
        if (!bus.request) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q <= CNT_W'(1)) begin
          // Saturate at zero rather than wrapping.
          cnt_d   = '0;
          state_d = RESPOND;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_respond = (state_q == RESPOND);
  assign oor        = (req_q.idx >= 30'(DEPTH));

  // A reset landing on the respond cycle must not let the store through.
  assign strobe = (in_respond && req_q.we && !oor && !reset) ? req_q.be : '0;

  ram_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank (
    .clock  (clock),
    .index  (req_q.idx[AW-1:0]),
    .strobe (strobe),
    .wdata  (req_q.wd),
    .rdata  (rdata)
  );

  always_comb begin
    rsp       = '0;
    rsp.ready = in_respond;
    rsp.error = in_respond && oor;
    if (in_respond && !req_q.we && !oor) rsp.data = rdata;
  end

  assign bus.ready     = rsp.ready;
  assign bus.error     = rsp.error;
  assign bus.read_data = rsp.data;

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench: two responders (1024 words / latency 2, 4 words / latency 1)
// share stimulus; sel picks which one sees the request.
module tb_ram_responder;
  import ram_responder_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sel, req, we;
  logic [31:0] addr, wd;
  logic [3:0]  be;

  always #5 clock = ~clock;

  ram_responder_if ifa ();
  ram_responder_if ifb ();

  assign ifa.request      = req & ~sel;
  assign ifa.write_enable = we;
  assign ifa.address      = addr;
  assign ifa.byte_select  = be;
  assign ifa.write_data   = wd;
  assign ifb.request      = req & sel;
  assign ifb.write_enable = we;
  assign ifb.address      = addr;
  assign ifb.byte_select  = be;
  assign ifb.write_data   = wd;

  ram_responder #(.DEPTH(1024), .LATENCY(2)) u_a (.clock(clock), .reset(reset), .bus(ifa));
  ram_responder #(.DEPTH(4),    .LATENCY(1)) u_b (.clock(clock), .reset(reset), .bus(ifb));

  logic        rdy, err;
  logic [31:0] rd;
  assign rdy = sel ? ifb.ready     : ifa.ready;
  assign err = sel ? ifb.error     : ifa.error;
  assign rd  = sel ? ifb.read_data : ifa.read_data;

  typedef struct { logic [31:0] rd; logic err; } exp_t;
  exp_t        sb[$];
  logic [31:0] mdl_a [1024];
  logic [31:0] mdl_b [4];
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  // One complete access; entered and left at a negedge.
  task automatic xact(input string tag, input bit s, input bit w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d, input bit wiggle = 1'b0);
    int          lat   = s ? 1 : 2;
    int          depth = s ? 4 : 1024;
    logic [29:0] idx   = a[31:2];
    bit          oor   = (idx >= 30'(depth));
    logic [31:0] cur;
    exp_t        e;
    int          n = 0;
    bit          got = 1'b0;
    cur   = oor ? 32'h0 : (s ? mdl_b[idx[1:0]] : mdl_a[idx[9:0]]);
    e.rd  = (!w && !oor) ? cur : 32'h0;
    e.err = oor;
    sb.push_back(e);
    if (w && !oor) begin
      for (int i = 0; i < 4; i++) if (b[i]) cur[8*i +: 8] = d[8*i +: 8];
      if (s) mdl_b[idx[1:0]] = cur; else mdl_a[idx[9:0]] = cur;
    end
    sel = s; we = w; addr = a; be = b; wd = d; req = 1'b1;
    while (!got && n < 20) begin
      cyc();
      n++;
      if (rdy) got = 1'b1;
      else if (wiggle && n == 1) begin
        wd = ~d; be = ~b; addr = a ^ 32'h4; we = ~w;
      end
    end
    chk({tag, " latency"}, n, lat);
    e = sb.pop_front();
    chk({tag, " read_data"}, rd, e.rd);
    chk({tag, " error"}, {31'b0, err}, {31'b0, e.err});
    req = 1'b0;
    cyc();
    chk({tag, " single pulse"}, {31'b0, rdy}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [3:0] pat;
    sel = 1'b0; req = 1'b0; we = 1'b0; addr = '0; be = '0; wd = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("reset a ready", {31'b0, ifa.ready}, 32'h0);
    chk("reset a error", {31'b0, ifa.error}, 32'h0);
    chk("reset a rdata", ifa.read_data, 32'h0);
    chk("reset b ready", {31'b0, ifb.ready}, 32'h0);
    reset = 1'b0;
    cyc();

    xact("st 0x8", 0, 1, 32'h8, 4'hF, 32'h44556677);
    xact("ld 0x8", 0, 0, 32'h8, 4'hF, 32'h0);
    xact("st0 0x0", 0, 1, 32'h0, 4'hF, 32'h00000000);
    xact("st lane1", 0, 1, 32'h0, 4'b0010, 32'h0000EE00);
    xact("ld lane1", 0, 0, 32'h0, 4'hF, 32'h0);
    xact("st lane23", 0, 1, 32'h0, 4'b1100, 32'hAABB0000);
    xact("ld lane23", 0, 0, 32'h0, 4'hF, 32'h0);
    chk("merged const", mdl_a[0], 32'hAABBEE00);
    xact("st be0", 0, 1, 32'h8, 4'b0000, 32'hFFFFFFFF);
    xact("ld be0", 0, 0, 32'hB, 4'hF, 32'h0);

    // Fields changed after acceptance must be ignored.
    xact("st 0x10", 0, 1, 32'h10, 4'hF, 32'h0BADF00D);
    xact("st wiggle", 0, 1, 32'h14, 4'hF, 32'h01020304, 1'b1);
    xact("ld 0x14", 0, 0, 32'h14, 4'hF, 32'h0);
    xact("ld 0x10", 0, 0, 32'h10, 4'hF, 32'h0);

    // Abort: request withdrawn one cycle after acceptance.
    xact("st 0x4", 0, 1, 32'h4, 4'hF, 32'h00008899);
    sel = 0; we = 1; addr = 32'h4; be = 4'hF; wd = 32'hFFFFFFFF; req = 1;
    cyc();
    req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (rdy) cnt++;
      cyc();
    end
    chk("abort ready count", cnt, 0);
    xact("ld after abort", 0, 0, 32'h4, 4'hF, 32'h0);
    chk("abort const", mdl_a[1], 32'h00008899);

    // Reset on the respond cycle of a store.
    xact("st 0xC", 0, 1, 32'hC, 4'hF, 32'h11112222);
    sel = 0; we = 1; addr = 32'hC; be = 4'hF; wd = 32'h0000CCDD; req = 1;
    cnt = 0;
    while (!rdy && cnt < 20) begin cyc(); cnt++; end
    chk("rst-respond reached", {31'b0, rdy}, 32'h1);
    reset = 1'b1;
    cyc();
    chk("rst-respond ready", {31'b0, ifa.ready}, 32'h0);
    chk("rst-respond error", {31'b0, ifa.error}, 32'h0);
    chk("rst-respond rdata", ifa.read_data, 32'h0);
    reset = 1'b0; req = 1'b0;
    cyc();
    xact("ld 0xC old", 0, 0, 32'hC, 4'hF, 32'h0);

    // Small instance: range errors.
    xact("b st 0x0", 1, 1, 32'h0, 4'hF, 32'h12345678);
    xact("b ld oor", 1, 0, 32'h10, 4'hF, 32'h0);
    xact("b st oor", 1, 1, 32'h10, 4'hF, 32'hDEADBEEF);
    xact("b st hi oor", 1, 1, 32'h80000000, 4'hF, 32'hDEADBEEF);
    xact("b ld 0x0", 1, 0, 32'h0, 4'hF, 32'h0);

    // Back-to-back loads with request held continuously.
    xact("b st 0x4", 1, 1, 32'h4, 4'hF, 32'h5555AAAA);
    sel = 1; we = 0; addr = 32'h4; be = 4'hF; req = 1;
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      pat[i] = rdy;
      if (rdy) chk("b2b read_data", rd, mdl_b[1]);
    end
    req = 1'b0;
    chk("b2b ready pattern", {28'b0, pat}, 32'h5);
    cyc();
    chk("b2b idle", {31'b0, rdy}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words in storage (power of two, at least 2).
REQ-002 SHALL have parameter LATENCY, default 2, meaning the number of cycles from request acceptance to ready (1..15).
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port request, input, 1 bit: the initiator requests a transfer; held high until ready.
REQ-006 SHALL have port write_enable, input, 1 bit: 1 = store, 0 = load; stable while request is high.
REQ-007 SHALL have port address, input, 32 bits: byte address; bits [1:0] are ignored and word index = address[31:2].
REQ-008 SHALL have port byte_select, input, 4 bits: bit i enables data bits [8i+7:8i]; stable while request is high.
REQ-009 SHALL have port write_data, input, 32 bits: store data, already lane-aligned by the initiator.
REQ-010 SHALL have port read_data, output, 32 bits: full load word, unmasked; valid only while ready is high.
REQ-011 SHALL have port ready, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port error, output, 1 bit: asserted with ready when the access is out of range.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESPOND.
REQ-014 SHALL in IDLE, with request high, latch write_enable/address/byte_select/write_data, load the counter with LATENCY-1, and go to WAIT, or to RESPOND directly if LATENCY=1.
REQ-015 SHALL in WAIT decrement the counter each cycle and go to RESPOND when it reaches 0; if request first seen in cycle N, ready is high in cycle N+LATENCY.
REQ-016 SHALL in WAIT, if request drops, abort to IDLE next cycle: no ready, no error, no storage write.
REQ-017 SHALL in RESPOND drive ready=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-018 SHALL treat a request high in the cycle after RESPOND as a new transaction; minimum turnaround is LATENCY+1 cycles per access.
REQ-019 SHALL commit a store on the RESPOND cycle's closing edge, writing only lanes whose byte_select bit is set; byte_select=0000 writes nothing but still completes.
REQ-020 SHALL for a load drive read_data = storage word at the latched index during RESPOND, and 0x00000000 in all other cycles.
REQ-021 SHALL flag out of range when latched address[31:2] >= DEPTH: ready=1 and error=1 in RESPOND, no write, read_data=0.
REQ-022 SHALL use latched request fields only; input changes after acceptance SHALL have no effect.
REQ-023 SHALL make a load following a store to the same word return the merged data.
REQ-024 SHALL size the counter as 4 bits with no wrap-around; it SHALL never decrement below 0.

Reset
REQ-025 SHALL on reset high at a rising edge force state to IDLE, counter to 0, ready=0, error=0, read_data=0, including mid-WAIT or mid-RESPOND.
REQ-026 SHALL NOT commit any pending store when reset coincides with RESPOND.
REQ-027 SHALL NOT clear storage contents on reset; they are undefined until written.

Structure
REQ-028 SHALL take FSM state encodings and default DEPTH/LATENCY constants from the shared memory defines package.
REQ-029 SHALL place storage in one sub-module ram_bank (clock, word index, 4-bit lane write strobe, write data, asynchronous read data); the FSM and counter stay in ram_responder.

Verification
REQ-030 Store and load, LATENCY=2: store word 0x44556677 at 0x8, load 0x8 -> ready exactly 2 cycles after each request, read_data=0x44556677.
REQ-031 Lane masking: store 0x00000000 to 0x0, then byte_select=0010 with data 0x0000EE00 -> load 0x0 returns 0x0000EE00; then byte_select=1100 with 0xAABB0000 -> load returns 0xAABBEE00.
REQ-032 Out of range: DEPTH=4, load or store at 0x10 -> ready=1, error=1, read_data=0; word 0 contents unchanged.
REQ-033 Abort: request drops one cycle after acceptance of a store of 0xFFFFFFFF to 0x4 -> no ready, word 0x4 retains its prior value 0x00008899.
REQ-034 Reset in RESPOND: store 0xCCDD to 0xC with reset asserted on the ready cycle -> outputs 0 next cycle; subsequent load of 0xC returns the old value.
REQ-035 Back-to-back with LATENCY=1: request held continuously for two loads -> ready in cycles N+1 and N+3, never in consecutive cycles.
